line_window_buf: RTL and testbench
==================================

Name: line_window_buf

Overview:
- Upstream neighbour of the 3x3 convolution stages.
- Converts a raster pixel stream (one pixel per clk while dv_i is high) into a vertical column of M_DEPTH pixels.
- The column holds the current line plus the same column position from the M_DEPTH-1 previous lines, held in cascaded line memories.
- Output timing strobes are delayed to stay aligned with the column, so the convolution stage can consume vect_o directly.

Parameters:
- COLORDEPTH, 8: bits per pixel.
- M_DEPTH, 3: window height (rows in vect_o). Supported range 2..5. Uses M_DEPTH-1 line memories.
- MAX_WIDTH, 2048: maximum active pixels per line (depth of each line memory).
- ADDR_W, $clog2(MAX_WIDTH): derived column address width. Not to be overridden.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- pix_i  input  COLORDEPTH  incoming pixel, valid when dv_i=1.
- dv_i  input  1  data valid (active pixel).
- hs_i  input  1  horizontal sync, passed through.
- vs_i  input  1  vertical sync. A rising edge marks frame start.
- vect_o  output  COLORDEPTH x M_DEPTH  unpacked array. [0] = current line, [k] = line k above.
- dv_o  output  1  dv_i delayed 1 clk.
- hs_o  output  1  hs_i delayed 1 clk.
- vs_o  output  1  vs_i delayed 1 clk.
- rows_valid_o  output  M_DEPTH-1  bit k-1 set when vect_o[k] holds real frame data.
- overflow_o  output  1  sticky: a line exceeded MAX_WIDTH pixels in the current frame.

Behaviour:
- Reset (rst=1 at posedge): col counter=0, line_cnt=0, all outputs 0, delay regs 0. Line memory contents are not cleared; they are masked by line_cnt. Reset mid-line aborts the line; the next dv_i starts at column 0.
- Column counter (ADDR_W bits):
  - +1 per clk with dv_i=1.
  - Cleared on dv_i falling edge (dv_q=1, dv_i=0).
  - At MAX_WIDTH-1 with dv_i=1 it holds. Further pixels are not written to memory, but they are still output with rows [1..] = 0, and overflow_o is set.
- Line memories mem[0..M_DEPTH-2], each MAX_WIDTH x COLORDEPTH, with synchronous read. When dv_i=1 at column c (not overflowed), in the same posedge:
  - Read mem[j][c] for every j (read-before-write).
  - Write mem[0][c] <= pix_i.
  - Write mem[j][c] <= old mem[j-1][c] for j>=1.
- vect_o, registered, 1 clk latency from pix_i:
  - vect_o[0] = pix_i.
  - vect_o[k] = mem[k-1][c] read value if line_cnt>=k, else 0 (see EDGE_REPLICATE_EN).
  - All vect_o entries are 0 in cycles where dv_o=0.
- line_cnt (0..M_DEPTH-1, saturating):
  - +1 on each dv_i falling edge.
  - Cleared on vs_i rising edge (vs_q=0, vs_i=1).
  - If a vs rising edge and a dv falling edge coincide, frame start wins (line_cnt=0).
- rows_valid_o[k-1] = (line_cnt>=k), registered alongside vect_o.
- overflow_o: set on overflow, cleared on vs_i rising edge or rst. If both occur in the same cycle, the clear wins.
- dv_o, hs_o and vs_o are plain 1-clk delays. They do not depend on line_cnt, so the first lines of a frame still flow to the next stage.
- Lines shorter than the previous line are allowed: only written columns are updated, and stale columns are never read, because reads follow the new line's columns.

Optional Feature:
- Macro: LINE_WINDOW_EDGE_REPLICATE_EN.
- Defined: for a row k not yet valid (line_cnt<k), vect_o[k] = the newest valid row's value at that column (row 0 if none). This replicates the top image edge instead of zero-padding. rows_valid_o is unchanged.
- Undefined: invalid rows output 0 (zero-padding).

Test Plan:
- Reset release, then frame start (vs 0->1), then line 0 of 4 pixels 10,20,30,40.
  - vect_o[0] = 10,20,30,40 one clk after each input; vect_o[1]=vect_o[2]=0; rows_valid_o=2'b00; dv_o is dv_i delayed 1 clk.
- Continue with line 1 = 11,21,31,41 and line 2 = 12,22,32,42.
  - Line 2 output columns are {12,11,10}, {22,21,20}, {32,31,30}, {42,41,40} as (vect_o[0],[1],[2]).
  - rows_valid_o = 2'b01 during line 1 and 2'b11 during line 2.
- New vs rising edge after 3 lines, then line of pixel 99.
  - vect_o = {99,0,0}, rows_valid_o=2'b00.
  - With LINE_WINDOW_EDGE_REPLICATE_EN: vect_o = {99,99,99}.
- MAX_WIDTH=4, send a 6-pixel line.
  - overflow_o rises at the 5th pixel and stays 1 until the next vs rising edge.
  - The next line's rows[1] at columns 0..3 equal the first 4 pixels of the overflowed line.
- rst pulse for 1 clk in the middle of line 2, then a fresh line 5,6.
  - All outputs 0 the cycle after rst.
  - The fresh line outputs {5,0,0}, {6,0,0}; rows_valid_o=0.
- vs rising edge coincident with a dv falling edge.
  - line_cnt=0 afterwards, so the next line has rows_valid_o=2'b00.

Source files
------------

// File: rtl/line_window_buf.sv
// line_window_buf: turns a raster pixel stream into a vertical column of
// M_DEPTH pixels (current line plus the M_DEPTH-1 previous lines at the
// same column) for the downstream 3x3 convolution stages.
// Optional feature macro: LINE_WINDOW_EDGE_REPLICATE_EN. When it is defined,
// rows that are not yet valid repeat the newest valid row. When it is not
// defined, those rows are zero-padded.
module line_window_buf #(
    parameter int COLORDEPTH = 8,
    parameter int M_DEPTH    = 3,
    parameter int MAX_WIDTH  = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] pix_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] vect_o [M_DEPTH],
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [M_DEPTH-2:0]    rows_valid_o,
    output logic                  overflow_o
);

    localparam int ADDR_W = $clog2(MAX_WIDTH);
    localparam int LC_W   = $clog2(M_DEPTH);

    logic [ADDR_W-1:0]     col;
    logic                  full;      // the current line has filled every memory column
    logic                  wr_q;      // the pixel now in pix_q was stored in memory
    logic [LC_W-1:0]       line_cnt;
    logic [COLORDEPTH-1:0] pix_q;
    logic [COLORDEPTH-1:0] rd_q [M_DEPTH-1];
    logic [COLORDEPTH-1:0] mem  [M_DEPTH-1][MAX_WIDTH];

    logic dv_fall;
    logic vs_rise;
    logic wr_en;

    // dv_o and vs_o double as the previous-cycle copies used for edge detection.
    assign dv_fall = dv_o & ~dv_i;
    assign vs_rise = vs_i & ~vs_o;
    assign wr_en   = dv_i & ~full & ~rst;

    // Column/line tracking, strobe delays and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            full         <= 1'b0;
            wr_q         <= 1'b0;
            line_cnt     <= '0;
            pix_q        <= '0;
            dv_o         <= 1'b0;
            hs_o         <= 1'b0;
            vs_o         <= 1'b0;
            rows_valid_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            dv_o  <= dv_i;
            hs_o  <= hs_i;
            vs_o  <= vs_i;
            pix_q <= pix_i;
            wr_q  <= wr_en;

            if (dv_fall) begin
                col  <= '0;
                full <= 1'b0;
            end else if (dv_i) begin
                if (col == ADDR_W'(MAX_WIDTH - 1))
                    full <= 1'b1;
                else
                    col <= col + 1'b1;
            end

            // A frame start takes priority over a line end that happens in the same cycle.
            if (vs_rise)
                line_cnt <= '0;
            else if (dv_fall && line_cnt != LC_W'(M_DEPTH - 1))
                line_cnt <= line_cnt + 1'b1;

            if (vs_rise)
                overflow_o <= 1'b0;
            else if (dv_i && full)
                overflow_o <= 1'b1;

            for (int unsigned k = 1; k < M_DEPTH; k++)
                rows_valid_o[k-1] <= (line_cnt >= LC_W'(k));
        end
    end

    // Cascaded line memories: each memory reads its old value first, then the
    // column shifts down by one line.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rd_q[0]     <= mem[0][col];
            mem[0][col] <= pix_i;
            for (int unsigned j = 1; j < M_DEPTH - 1; j++) begin
                rd_q[j]     <= mem[j][col];
                mem[j][col] <= mem[j-1][col];
            end
        end
    end

`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
    logic [COLORDEPTH-1:0] newest;
`endif

    // Output column: rows that have no frame data yet, and pixels past the overflow point, are masked.
    always_comb begin
        for (int unsigned k = 0; k < M_DEPTH; k++)
            vect_o[k] = '0;
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
        newest = pix_q;
`endif
        if (dv_o) begin
            vect_o[0] = pix_q;
            if (wr_q) begin
                for (int unsigned k = 1; k < M_DEPTH; k++) begin
                    if (rows_valid_o[k-1])
                        vect_o[k] = rd_q[k-1];
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
                    else
                        vect_o[k] = newest;
                    newest = vect_o[k];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_line_window_buf.sv
// Directed testbench for line_window_buf (MAX_WIDTH reduced to 4 so that the
// overflow case can be reached with short lines). The expected values follow
// LINE_WINDOW_EDGE_REPLICATE_EN when that macro is defined.
module tb_line_window_buf;

    localparam int CD = 8;
    localparam int MD = 3;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CD-1:0] pix_i;
    logic          dv_i;
    logic          hs_i;
    logic          vs_i;
    logic [CD-1:0] vect [MD];
    logic          dv_o;
    logic          hs_o;
    logic          vs_o;
    logic [MD-2:0] rows_valid;
    logic          overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    line_window_buf #(
        .COLORDEPTH(CD),
        .M_DEPTH   (MD),
        .MAX_WIDTH (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_i       (pix_i),
        .dv_i        (dv_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .vect_o      (vect),
        .dv_o        (dv_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .rows_valid_o(rows_valid),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    // Every comparison goes through here.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one cycle's inputs on the falling edge, then return 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic v, input logic d, input int p);
        @(negedge clk);
        rst   = r;
        vs_i  = v;
        dv_i  = d;
        hs_i  = ~d;
        pix_i = CD'(p);
        @(posedge clk);
        #1;
    endtask

    // e1/e2 are the zero-padded expectations. ovpix marks a pixel past the line memory.
    task automatic chk_out(input string tag, input int e0, input int e1, input int e2,
                           input logic [1:0] rv, input logic edv, input logic eov,
                           input logic ovpix);
        int x1;
        int x2;
        x1 = e1;
        x2 = e2;
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
        if (edv && !ovpix) begin
            if (!rv[0]) x1 = e0;
            if (!rv[1]) x2 = x1;
        end
`endif
        check({tag, ".v0"}, 32'(vect[0]), 32'(e0));
        check({tag, ".v1"}, 32'(vect[1]), 32'(x1));
        check({tag, ".v2"}, 32'(vect[2]), 32'(x2));
        check({tag, ".rv"}, 32'(rows_valid), 32'(rv));
        check({tag, ".dv"}, 32'(dv_o), 32'(edv));
        check({tag, ".ov"}, 32'(overflow), 32'(eov));
    endtask

    initial begin
        rst = 1'b1; vs_i = 1'b0; dv_i = 1'b0; hs_i = 1'b0; pix_i = '0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk_out("reset", 0, 0, 0, 2'b00, 0, 0, 0);
        check("reset.hs", 32'(hs_o), 0);
        check("reset.vs", 32'(vs_o), 0);

        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        check("fs0.vs_o", 32'(vs_o), 1);

        // Three lines of 4 pixels each.
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 10 * i);
            chk_out("line0", 10 * i, 0, 0, 2'b00, 1, 0, 0);
        end
        drive(0, 0, 0, 0);
        chk_out("gap0", 0, 0, 0, 2'b00, 0, 0, 0);
        check("gap0.hs", 32'(hs_o), 1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 10 * i + 1);
            chk_out("line1", 10 * i + 1, 10 * i, 0, 2'b01, 1, 0, 0);
        end
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 10 * i + 2);
            chk_out("line2", 10 * i + 2, 10 * i + 1, 10 * i, 2'b11, 1, 0, 0);
        end
        drive(0, 0, 0, 0);

        // New frame: previous lines are masked.
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 99);
        chk_out("newframe", 99, 0, 0, 2'b00, 1, 0, 0);
        drive(0, 0, 0, 0);

        // Overflow: a 6-pixel line into 4-column memories.
        drive(0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 1, i);
            chk_out("ovline", i, 0, 0, 2'b00, 1, i >= 5, i >= 5);
        end
        drive(0, 0, 0, 0);
        chk_out("ovgap", 0, 0, 0, 2'b00, 0, 1, 0);
        for (int i = 7; i <= 10; i++) begin
            drive(0, 0, 1, i);
            chk_out("postov", i, i - 6, 0, 2'b01, 1, 1, 0);
        end
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        check("ovclear", 32'(overflow), 0);

        // Reset in the middle of line 2.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 50 + i);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 60 + i);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 70);
        chk_out("midl2", 70, 60, 50, 2'b11, 1, 0, 0);
        drive(0, 0, 1, 71);
        drive(1, 0, 1, 72);
        chk_out("midrst", 0, 0, 0, 2'b00, 0, 0, 0);
        check("midrst.hs", 32'(hs_o), 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 5);
        chk_out("fresh5", 5, 0, 0, 2'b00, 1, 0, 0);
        drive(0, 0, 1, 6);
        chk_out("fresh6", 6, 0, 0, 2'b00, 1, 0, 0);
        drive(0, 0, 0, 0);

        // vs rising edge in the same cycle as a dv falling edge.
        drive(0, 0, 1, 33);
        chk_out("pre_coinc", 33, 5, 0, 2'b01, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 44);
        chk_out("post_coinc", 44, 0, 0, 2'b00, 1, 0, 0);
        drive(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
